// File: rtl/tv80_regctl.sv
// TV80 register-port controller: logical->physical pair mapping (EXX / EX DE,HL),
// port-A write mux, and the block-instruction pair-update sequencer.

module tv80_regctl_map (
  input  logic [2:0] sel,
  input  logic       alt,
  input  logic [1:0] swap,
  output logic [2:0] phys
);
  always_comb begin
    phys = sel;
    if (sel < 3'd3) begin
      // DE<->HL swap: ~01 = 10 and ~10 = 01, BC (00) is never swapped
      if (swap[alt] && sel[1:0] != 2'd0) phys = {alt, ~sel[1:0]};
      else                                phys = {alt, sel[1:0]};
    end
  end
endmodule

module tv80_regctl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cen,
  input  logic [2:0]  sel_a,
  input  logic [2:0]  sel_b,
  input  logic [2:0]  sel_c,
  input  logic        wr_h,
  input  logic        wr_l,
  input  logic [15:0] wr_data,
  input  logic [15:0] doa,
  input  logic        exx,
  input  logic        ex_dehl,
  input  logic        blk_start,
  input  logic [1:0]  blk_mode,
  output logic [2:0]  AddrA,
  output logic [2:0]  AddrB,
  output logic [2:0]  AddrC,
  output logic [7:0]  DIH,
  output logic [7:0]  DIL,
  output logic        WEH,
  output logic        WEL,
  output logic        CEN,
  output logic        blk_busy,
  output logic        blk_done,
  output logic        bc_zero,
  output logic        wr_drop
);

  typedef enum logic [2:0] {IDLE, S_BC, S_DE, S_HL, DONE} state_t;

  state_t            state;
  logic              alt;
  logic [1:0]        swap;
  logic              seq_wr;
  logic [2:0]        pair;
  logic              dec;
  logic [15:0]       res;
  logic [2:0][2:0]   sel_v;
  logic [2:0][2:0]   phys_v;

  assign blk_busy = (state != IDLE);
  assign blk_done = (state == DONE);
  assign seq_wr   = (state == S_BC) || (state == S_DE) || (state == S_HL);
  assign CEN      = cen;

  always_comb begin
    pair = 3'd0;
    case (state)
      S_DE:    pair = 3'd1;
      S_HL:    pair = 3'd2;
      default: pair = 3'd0;
    endcase
  end

  // BC always counts down; DE/HL direction comes from blk_mode[0]
  assign dec = (state == S_BC) || blk_mode[0];
  assign res = dec ? (doa - 16'd1) : (doa + 16'd1);

  assign sel_v[0] = seq_wr ? pair : sel_a;
  assign sel_v[1] = sel_b;
  assign sel_v[2] = sel_c;

  for (genvar i = 0; i < 3; i++) begin : g_map
    tv80_regctl_map u_map (
      .sel  (sel_v[i]),
      .alt  (alt),
      .swap (swap),
      .phys (phys_v[i])
    );
  end

  assign AddrA = phys_v[0];
  assign AddrB = phys_v[1];
  assign AddrC = phys_v[2];

  always_comb begin
    {DIH, DIL} = wr_data;
    WEH        = wr_h;
    WEL        = wr_l;
    if (seq_wr) begin
      {DIH, DIL} = res;
      WEH        = 1'b1;
      WEL        = 1'b1;
    end else if (blk_busy) begin
      WEH = 1'b0;
      WEL = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      alt     <= 1'b0;
      swap    <= 2'b00;
      bc_zero <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= cen && blk_busy && (wr_h || wr_l);
      if (cen) begin
        case (state)
          IDLE: begin
            if (exx)       alt       <= ~alt;
            if (ex_dehl)   swap[alt] <= ~swap[alt];
            if (blk_start) state     <= S_BC;
          end
          S_BC: begin
            bc_zero <= (res == 16'h0000);
            state   <= blk_mode[1] ? S_HL : S_DE;
          end
          S_DE:    state <= S_HL;
          S_HL:    state <= DONE;
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tv80_regctl.sv
// Directed bench for tv80_regctl with a behavioural 8x16 register file on port A.

module tb_tv80_regctl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cen = 1'b0;
  logic [2:0]  sel_a = 3'd0, sel_b = 3'd0, sel_c = 3'd0;
  logic        wr_h = 1'b0, wr_l = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic [15:0] doa;
  logic        exx = 1'b0, ex_dehl = 1'b0, blk_start = 1'b0;
  logic [1:0]  blk_mode = 2'b00;
  logic [2:0]  AddrA, AddrB, AddrC;
  logic [7:0]  DIH, DIL;
  logic        WEH, WEL, CEN, blk_busy, blk_done, bc_zero, wr_drop;

  logic [15:0] rf [8];
  int n_tot = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tv80_regctl dut (
    .clk(clk), .reset_n(reset_n), .cen(cen),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c),
    .wr_h(wr_h), .wr_l(wr_l), .wr_data(wr_data), .doa(doa),
    .exx(exx), .ex_dehl(ex_dehl), .blk_start(blk_start), .blk_mode(blk_mode),
    .AddrA(AddrA), .AddrB(AddrB), .AddrC(AddrC),
    .DIH(DIH), .DIL(DIL), .WEH(WEH), .WEL(WEL), .CEN(CEN),
    .blk_busy(blk_busy), .blk_done(blk_done), .bc_zero(bc_zero), .wr_drop(wr_drop)
  );

  // register file model: writes qualified by CEN
  assign doa = rf[AddrA];
  always @(posedge clk) begin
    if (CEN && WEH) rf[AddrA][15:8] <= DIH;
    if (CEN && WEL) rf[AddrA][7:0]  <= DIL;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wr_pair(input logic [2:0] s, input logic [15:0] d);
    sel_a = s; wr_data = d; wr_h = 1'b1; wr_l = 1'b1;
    tick();
    wr_h = 1'b0; wr_l = 1'b0;
  endtask

  task automatic pulse(input logic x, input logic e);
    exx = x; ex_dehl = e;
    tick();
    exx = 1'b0; ex_dehl = 1'b0;
  endtask

  initial begin
    // reset state, cen low so nothing is written
    wr_h = 1'b1; wr_data = 16'hBEEF; sel_a = 3'd1; sel_b = 3'd2; sel_c = 3'd7;
    #3;
    chk("rst_busy",  {15'd0, blk_busy}, 16'd0);
    chk("rst_done",  {15'd0, blk_done}, 16'd0);
    chk("rst_bcz",   {15'd0, bc_zero},  16'd0);
    chk("rst_drop",  {15'd0, wr_drop},  16'd0);
    chk("rst_weh",   {14'd0, WEH, WEL}, 16'b10);
    chk("rst_di",    {DIH, DIL},        16'hBEEF);
    chk("rst_addr",  {7'd0, AddrA, AddrB, AddrC}, {7'd0, 3'd1, 3'd2, 3'd7});
    wr_h = 1'b0;
    reset_n = 1'b1;
    cen = 1'b1;
    tick();

    // mapping walk
    pulse(1'b0, 1'b1);
    chk("map_swap0", {13'd0, AddrA}, 16'd2);
    chk("map_b_sw0", {13'd0, AddrB}, 16'd1);
    pulse(1'b1, 1'b0);
    chk("map_alt1",  {13'd0, AddrA}, 16'd5);
    pulse(1'b0, 1'b1);
    chk("map_sw1",   {13'd0, AddrA}, 16'd6);
    chk("map_b_sw1", {13'd0, AddrB}, 16'd5);
    sel_a = 3'd3; #1;
    chk("map_ix",    {13'd0, AddrA}, 16'd3);
    chk("map_iy",    {13'd0, AddrC}, 16'd7);

    // simultaneous exx + ex_dehl toggles swap of the old bank
    do_reset();
    sel_a = 3'd0;
    pulse(1'b1, 1'b1);
    sel_a = 3'd1; #1;
    chk("sim_bank1", {13'd0, AddrA}, 16'd5);
    pulse(1'b1, 1'b0);
    chk("sim_bank0", {13'd0, AddrA}, 16'd2);

    // LDI: BC=1 DE=1000 HL=FFFF
    do_reset();
    wr_pair(3'd0, 16'h0001); wr_pair(3'd1, 16'h1000); wr_pair(3'd2, 16'hFFFF);
    chk("pre_de", rf[1], 16'h1000);
    blk_mode = 2'b00; blk_start = 1'b1;
    tick(); blk_start = 1'b0;
    chk("ldi_bc_di", {DIH, DIL}, 16'h0000);
    chk("ldi_busy",  {15'd0, blk_busy}, 16'd1);
    tick();
    chk("ldi_de_a",  {13'd0, AddrA}, 16'd1);
    chk("ldi_de_di", {DIH, DIL}, 16'h1001);
    tick();
    chk("ldi_hl_di", {DIH, DIL}, 16'h0000);
    tick();
    chk("ldi_done",  {15'd0, blk_done}, 16'd1);
    chk("ldi_we_dn", {14'd0, WEH, WEL}, 16'd0);
    tick();
    chk("ldi_idle",  {14'd0, blk_busy, blk_done}, 16'd0);
    chk("ldi_bc",    rf[0], 16'h0000);
    chk("ldi_de",    rf[1], 16'h1001);
    chk("ldi_hl",    rf[2], 16'h0000);
    chk("ldi_bcz",   {15'd0, bc_zero}, 16'd1);

    // CPD: BC=0 HL=0, skip DE
    do_reset();
    wr_pair(3'd0, 16'h0000); wr_pair(3'd1, 16'h1234); wr_pair(3'd2, 16'h0000);
    blk_mode = 2'b11; blk_start = 1'b1;
    tick(); blk_start = 1'b0;
    tick();
    chk("cpd_hl_a",  {13'd0, AddrA}, 16'd2);
    tick();
    chk("cpd_done",  {15'd0, blk_done}, 16'd1);
    tick();
    chk("cpd_bc",    rf[0], 16'hFFFF);
    chk("cpd_de",    rf[1], 16'h1234);
    chk("cpd_hl",    rf[2], 16'hFFFF);
    chk("cpd_bcz",   {15'd0, bc_zero}, 16'd0);

    // LDI with cen stalls and a dropped external write
    do_reset();
    wr_pair(3'd0, 16'h0001); wr_pair(3'd1, 16'h1000); wr_pair(3'd2, 16'hFFFF);
    blk_mode = 2'b00; blk_start = 1'b1;
    tick(); blk_start = 1'b0;
    cen = 1'b0; tick();
    chk("cen_bc_hold", rf[0], 16'h0001);
    chk("cen_st_hold", {13'd0, AddrA}, 16'd0);
    cen = 1'b1; tick();
    chk("cen_bc_wr", rf[0], 16'h0000);
    cen = 1'b0; tick();
    chk("cen_de_hold", rf[1], 16'h1000);
    cen = 1'b1; wr_h = 1'b1; wr_data = 16'hAAAA;
    tick(); wr_h = 1'b0;
    chk("drop_pulse", {15'd0, wr_drop}, 16'd1);
    chk("drop_de",    rf[1], 16'h1001);
    cen = 1'b0; tick();
    chk("drop_clr",   {15'd0, wr_drop}, 16'd0);
    chk("cen_hl_hold", rf[2], 16'hFFFF);
    cen = 1'b1; tick();
    chk("cen_done",  {15'd0, blk_done}, 16'd1);
    tick();
    chk("cen_end", {rf[0][7:0], rf[2][7:0]}, 16'h0000);
    chk("cen_end_de", rf[1], 16'h1001);
    chk("cen_bcz", {15'd0, bc_zero}, 16'd1);

    // async reset in S_DE, then a full sequence
    do_reset();
    wr_pair(3'd0, 16'h0003); wr_pair(3'd1, 16'h0100); wr_pair(3'd2, 16'h0200);
    wr_pair(3'd4, 16'h0005); wr_pair(3'd5, 16'h0010);
    pulse(1'b1, 1'b0);
    blk_mode = 2'b00; blk_start = 1'b1;
    tick(); blk_start = 1'b0;
    tick();
    chk("ar_de_a", {13'd0, AddrA}, 16'd5);
    #2 reset_n = 1'b0; sel_a = 3'd1;
    #1;
    chk("ar_busy",  {15'd0, blk_busy}, 16'd0);
    chk("ar_map",   {13'd0, AddrA}, 16'd1);
    chk("ar_keep",  rf[4], 16'h0004);
    chk("ar_de_nw", rf[5], 16'h0010);
    @(negedge clk); reset_n = 1'b1;
    blk_start = 1'b1;
    tick(); blk_start = 1'b0;
    tick(); tick(); tick();
    chk("ar_done", {15'd0, blk_done}, 16'd1);
    tick();
    chk("ar_bc", rf[0], 16'h0002);
    chk("ar_de", rf[1], 16'h0101);
    chk("ar_hl", rf[2], 16'h0201);
    chk("ar_bcz", {15'd0, bc_zero}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
